sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Next-generation synchronous FIFO that succeeds the fixed sync_fifo. It adds arbitrary (non-power-of-two) depth, a selectable read mode (standard or first-word-fall-through), an occupancy count output, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer and a consumer in one clock domain and uses the same valid/ready naming.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
FIFO_DEPTH, 16, number of storage entries; any integer >=2, not restricted to powers of two
FWFT, 1, read mode: 1 = first-word-fall-through, 0 = standard registered read
ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width (derived; do not override)
CNT_WIDTH, $clog2(FIFO_DEPTH+1), occupancy/level width (derived; do not override)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous clear of FIFO contents
i_valid_s  input  1  producer write request
i_datain  input  DATA_WIDTH  write data
o_ready_s  output  1  FIFO can accept a write
i_ready_m  input  1  consumer read request/accept
o_valid_m  output  1  o_dataout holds valid data
o_dataout  output  DATA_WIDTH  read data
i_almostfull_lvl  input  CNT_WIDTH  free-entry threshold for o_almostfull
i_almostempty_lvl  input  CNT_WIDTH  occupancy threshold for o_almostempty
o_full  output  1  count == FIFO_DEPTH
o_almostfull  output  1  (FIFO_DEPTH - count) <= i_almostfull_lvl
o_empty  output  1  count == 0
o_almostempty  output  1  count <= i_almostempty_lvl
o_count  output  CNT_WIDTH  entries currently stored
o_overflow  output  1  sticky: write attempted while full
o_underflow  output  1  sticky: read attempted while empty (standard mode only)
i_clr_err  input  1  synchronous clear of the sticky error flags

Behaviour:
- Reset (i_rst_n low, asynchronous): wr_ptr = rd_ptr = count = 0; o_valid_m = 0; o_dataout = 0; o_overflow = o_underflow = 0. Consequently o_empty = 1, o_full = 0, o_ready_s = 1. Memory contents are not reset.
- Clock and reset: one clock domain, i_clk; reset is asynchronous and active-low on i_rst_n.
- Pointers: each pointer wraps from FIFO_DEPTH-1 to 0 by explicit compare, never by natural binary overflow. Full/empty are derived only from count.
- Write: push = i_valid_s & o_ready_s, where o_ready_s = !o_full. Data is written at wr_ptr and wr_ptr advances.
- Read, FWFT=1:
  - o_valid_m = !o_empty; o_dataout = mem[rd_ptr].
  - pop = o_valid_m & i_ready_m.
  - A write into an empty FIFO shows o_valid_m = 1 in the following cycle (1-cycle latency; no same-cycle bypass).
- Read, FWFT=0:
  - pop = i_ready_m & !o_empty.
  - o_dataout is registered with mem[rd_ptr] and o_valid_m pulses high in the cycle after the pop.
  - Otherwise o_valid_m = 0 and o_dataout holds its last value.
- Count update: +1 on push only, -1 on pop only, unchanged when push and pop coincide.
  - A simultaneous push and pop when full is impossible because o_ready_s = 0.
  - A simultaneous push and pop when empty is only a push: no bypass.
- Flags: o_full, o_empty, o_almostfull and o_almostempty are combinational from registered count and the level inputs. Level inputs may change at any time; the flags follow in the same cycle.
- Flush: when i_flush = 1 at a clock edge, pointers and count are cleared and o_valid_m = 0 next cycle. Flush has priority over push and pop in the same cycle; both are dropped and produce no error. Flush does not clear the error flags.
- Errors:
  - o_overflow sets on i_valid_s & o_full.
  - o_underflow sets on i_ready_m & o_empty when FWFT=0 (in FWFT mode, ready without valid is legal).
  - Both flags are sticky until i_clr_err. If a set condition and i_clr_err occur in the same cycle, set wins.
- Mid-operation reset: all state returns to reset values immediately; no partial transfer completes.

Decomposition:
- Shared header sync_fifo_defines.vh: default FIFO_DEPTH and DATA_WIDTH, plus named constants for the FWFT mode encodings (MODE_STD = 0, MODE_FWFT = 1).
- One sub-module, sync_fifo_flex_mem: a DATA_WIDTH x FIFO_DEPTH register array with synchronous write and asynchronous read by address. The top level holds pointer, count, flag, error and output-register logic.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 with FWFT=1 and i_ready_m=0 -> o_count=3, o_valid_m=1, o_dataout=0x11. Pop three times -> data 0x11, 0x22, 0x33 in order, then o_empty=1.
- FIFO_DEPTH=5: fill with 5 writes -> o_full=1, o_ready_s=0. A 6th i_valid_s -> o_overflow=1 and data unchanged. Then drain 5 and refill 5 -> pointers wrap 4->0 and read order is preserved.
- FWFT=0: with FIFO empty, i_ready_m=1 -> o_underflow=1 and o_valid_m stays 0. Then write 0xA5 and read -> o_valid_m pulses 1 cycle after the read with o_dataout=0xA5.
- Simultaneous push and pop at count=2 held for 10 cycles -> o_count stays 2 and output data is strictly FIFO-ordered.
- Level thresholds with DEPTH=16, i_almostfull_lvl=2, i_almostempty_lvl=3: count=14 -> o_almostfull=1; count=13 -> 0; count=3 -> o_almostempty=1; count=4 -> 0.
- i_flush with count=7 together with push and pop -> next cycle o_count=0, o_empty=1, o_valid_m=0, sticky flags unchanged. Assert i_rst_n low mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants for sync_fifo_flex: default geometry and read-mode encodings.
package sync_fifo_flex_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 16;

    localparam int unsigned MODE_STD  = 0;
    localparam int unsigned MODE_FWFT = 1;

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake bundle for sync_fifo_flex; names are from the FIFO's point of view.
interface sync_fifo_flex_if
    import sync_fifo_flex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  i_valid_s;
    logic [DATA_WIDTH-1:0] i_datain;
    logic                  o_ready_s;
    logic                  i_ready_m;
    logic                  o_valid_m;
    logic [DATA_WIDTH-1:0] o_dataout;

    modport slave (
        input  i_valid_s,
        input  i_datain,
        output o_ready_s,
        input  i_ready_m,
        output o_valid_m,
        output o_dataout
    );

    modport master (
        output i_valid_s,
        output i_datain,
        input  o_ready_s,
        output i_ready_m,
        input  o_valid_m,
        input  o_dataout
    );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// Storage array for sync_fifo_flex: synchronous write, asynchronous read by address.
module sync_fifo_flex_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with arbitrary depth, FWFT/standard read modes, level flags,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_flex
    import sync_fifo_flex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned FWFT       = MODE_FWFT,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    sync_fifo_flex_if.slave      bus,
    input  logic [CNT_WIDTH-1:0] i_almostfull_lvl,
    input  logic [CNT_WIDTH-1:0] i_almostempty_lvl,
    output logic                 o_full,
    output logic                 o_almostfull,
    output logic                 o_empty,
    output logic                 o_almostempty,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_overflow,
    output logic                 o_underflow,
    input  logic                 i_clr_err
);

    localparam logic [CNT_WIDTH-1:0]  LP_DEPTH = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(FIFO_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow, r_underflow;

    logic                  w_full, w_empty, w_push, w_pop;
    logic                  w_overflow_set, w_underflow_set;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [CNT_WIDTH-1:0]  w_free;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_free  = LP_DEPTH - r_count;

    // Flush drops any push/pop of the same cycle, and raises no error for them.
    assign w_push         = bus.i_valid_s & !w_full & !i_flush;
    assign w_overflow_set = bus.i_valid_s & w_full & !i_flush;

    sync_fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_datain),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign w_pop           = !w_empty & bus.i_ready_m & !i_flush;
        assign bus.o_valid_m   = !w_empty;
        // Gate stale array contents so an empty FIFO presents zero data.
        assign bus.o_dataout   = w_empty ? '0 : w_rdata;
        assign w_underflow_set = 1'b0;
    end else begin : g_std
        logic                  r_valid_m;
        logic [DATA_WIDTH-1:0] r_dataout;

        assign w_pop           = bus.i_ready_m & !w_empty & !i_flush;
        assign w_underflow_set = bus.i_ready_m & w_empty & !i_flush;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid_m <= 1'b0;
                r_dataout <= '0;
            end else begin
                r_valid_m <= w_pop;
                if (w_pop) begin
                    r_dataout <= w_rdata;
                end
            end
        end

        assign bus.o_valid_m = r_valid_m;
        assign bus.o_dataout = r_dataout;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_overflow_set | (r_overflow & !i_clr_err);
            r_underflow <= w_underflow_set | (r_underflow & !i_clr_err);
        end
    end

    assign bus.o_ready_s  = !w_full;
    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almostfull   = (w_free <= i_almostfull_lvl);
    assign o_almostempty  = (r_count <= i_almostempty_lvl);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: DUT A is 16-deep FWFT, DUT B is 5-deep standard-read.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // DUT A
    sync_fifo_flex_if #(.DATA_WIDTH(8)) bus_a ();
    logic       flush_a, clr_a, full_a, afull_a, empty_a, aempty_a, ovf_a, unf_a;
    logic [4:0] alf_a, ale_a, cnt_a;

    sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_dut_a (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_flush           (flush_a),
        .bus               (bus_a),
        .i_almostfull_lvl  (alf_a),
        .i_almostempty_lvl (ale_a),
        .o_full            (full_a),
        .o_almostfull      (afull_a),
        .o_empty           (empty_a),
        .o_almostempty     (aempty_a),
        .o_count           (cnt_a),
        .o_overflow        (ovf_a),
        .o_underflow       (unf_a),
        .i_clr_err         (clr_a)
    );

    // DUT B
    sync_fifo_flex_if #(.DATA_WIDTH(8)) bus_b ();
    logic       flush_b, clr_b, full_b, afull_b, empty_b, aempty_b, ovf_b, unf_b;
    logic [2:0] alf_b, ale_b, cnt_b;

    sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0)) u_dut_b (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_flush           (flush_b),
        .bus               (bus_b),
        .i_almostfull_lvl  (alf_b),
        .i_almostempty_lvl (ale_b),
        .o_full            (full_b),
        .o_almostfull      (afull_b),
        .o_empty           (empty_b),
        .o_almostempty     (aempty_b),
        .o_count           (cnt_b),
        .o_overflow        (ovf_b),
        .o_underflow       (unf_b),
        .i_clr_err         (clr_b)
    );

    task automatic push_a(input logic [7:0] d);
        bus_a.i_valid_s = 1'b1;
        bus_a.i_datain  = d;
        @(negedge clk);
        bus_a.i_valid_s = 1'b0;
    endtask

    task automatic pop_a();
        bus_a.i_ready_m = 1'b1;
        @(negedge clk);
        bus_a.i_ready_m = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        bus_b.i_valid_s = 1'b1;
        bus_b.i_datain  = d;
        @(negedge clk);
        bus_b.i_valid_s = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (cnt_a !== 0 || empty_a !== 1 || full_a !== 0 || bus_a.o_ready_s !== 1) begin
            n_err++; $display("FAIL reset_a_flags cnt=%0d empty=%b full=%b ready=%b exp 0/1/0/1",
                              cnt_a, empty_a, full_a, bus_a.o_ready_s); end
        n_cmp++; if (bus_a.o_valid_m !== 0 || bus_a.o_dataout !== 8'h00 || ovf_a !== 0 || unf_a !== 0) begin
            n_err++; $display("FAIL reset_a_out valid=%b data=%h ovf=%b unf=%b exp 0/00/0/0",
                              bus_a.o_valid_m, bus_a.o_dataout, ovf_a, unf_a); end
        n_cmp++; if (cnt_b !== 0 || empty_b !== 1 || full_b !== 0 || bus_b.o_ready_s !== 1) begin
            n_err++; $display("FAIL reset_b_flags cnt=%0d empty=%b full=%b ready=%b exp 0/1/0/1",
                              cnt_b, empty_b, full_b, bus_b.o_ready_s); end
        n_cmp++; if (bus_b.o_valid_m !== 0 || bus_b.o_dataout !== 8'h00 || ovf_b !== 0 || unf_b !== 0) begin
            n_err++; $display("FAIL reset_b_out valid=%b data=%h ovf=%b unf=%b exp 0/00/0/0",
                              bus_b.o_valid_m, bus_b.o_dataout, ovf_b, unf_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_fwft_basic();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        push_a(8'h11);
        n_cmp++; if (bus_a.o_valid_m !== 1) begin
            n_err++; $display("FAIL fwft_latency valid=%b exp 1", bus_a.o_valid_m); end
        push_a(8'h22);
        push_a(8'h33);
        n_cmp++; if (cnt_a !== 3 || bus_a.o_valid_m !== 1 || bus_a.o_dataout !== 8'h11) begin
            n_err++; $display("FAIL fwft_fill cnt=%0d valid=%b data=%h exp 3/1/11",
                              cnt_a, bus_a.o_valid_m, bus_a.o_dataout); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus_a.o_valid_m !== 1 || bus_a.o_dataout !== exp_d[i]) begin
                n_err++; $display("FAIL fwft_pop%0d valid=%b data=%h exp 1/%h",
                                  i, bus_a.o_valid_m, bus_a.o_dataout, exp_d[i]); end
            pop_a();
        end
        n_cmp++; if (empty_a !== 1 || bus_a.o_valid_m !== 0) begin
            n_err++; $display("FAIL fwft_empty empty=%b valid=%b exp 1/0", empty_a, bus_a.o_valid_m); end
    endtask

    task automatic test_underflow();
        bus_b.i_ready_m = 1'b1;
        @(negedge clk);
        bus_b.i_ready_m = 1'b0;
        n_cmp++; if (unf_b !== 1 || bus_b.o_valid_m !== 0) begin
            n_err++; $display("FAIL underflow_set unf=%b valid=%b exp 1/0", unf_b, bus_b.o_valid_m); end
        push_b(8'hA5);
        n_cmp++; if (bus_b.o_valid_m !== 0) begin
            n_err++; $display("FAIL std_no_early_valid valid=%b exp 0", bus_b.o_valid_m); end
        bus_b.i_ready_m = 1'b1;
        @(negedge clk);
        bus_b.i_ready_m = 1'b0;
        n_cmp++; if (bus_b.o_valid_m !== 1 || bus_b.o_dataout !== 8'hA5) begin
            n_err++; $display("FAIL std_read valid=%b data=%h exp 1/a5", bus_b.o_valid_m, bus_b.o_dataout); end
        @(negedge clk);
        n_cmp++; if (bus_b.o_valid_m !== 0 || bus_b.o_dataout !== 8'hA5) begin
            n_err++; $display("FAIL std_pulse valid=%b data=%h exp 0/a5", bus_b.o_valid_m, bus_b.o_dataout); end
        // Set and clear together: set wins.
        clr_b = 1'b1; bus_b.i_ready_m = 1'b1;
        @(negedge clk);
        bus_b.i_ready_m = 1'b0;
        n_cmp++; if (unf_b !== 1) begin
            n_err++; $display("FAIL underflow_set_wins unf=%b exp 1", unf_b); end
        @(negedge clk);
        clr_b = 1'b0;
        n_cmp++; if (unf_b !== 0) begin
            n_err++; $display("FAIL underflow_clear unf=%b exp 0", unf_b); end
    endtask

    task automatic test_overflow_wrap();
        for (int i = 0; i < 5; i++) push_b(8'h40 + 8'(i));
        n_cmp++; if (full_b !== 1 || bus_b.o_ready_s !== 0 || cnt_b !== 5) begin
            n_err++; $display("FAIL b_full full=%b ready=%b cnt=%0d exp 1/0/5", full_b, bus_b.o_ready_s, cnt_b); end
        push_b(8'hEE);
        n_cmp++; if (ovf_b !== 1 || cnt_b !== 5 || bus_b.o_dataout !== 8'hA5) begin
            n_err++; $display("FAIL b_overflow ovf=%b cnt=%0d data=%h exp 1/5/a5", ovf_b, cnt_b, bus_b.o_dataout); end
        for (int r = 0; r < 2; r++) begin
            bus_b.i_ready_m = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                n_cmp++; if (bus_b.o_valid_m !== 1 || bus_b.o_dataout !== 8'h40 + 8'(16 * r + i)) begin
                    n_err++; $display("FAIL wrap_r%0d_i%0d valid=%b data=%h exp 1/%h", r, i,
                                      bus_b.o_valid_m, bus_b.o_dataout, 8'h40 + 8'(16 * r + i)); end
            end
            bus_b.i_ready_m = 1'b0;
            n_cmp++; if (empty_b !== 1 || unf_b !== 0) begin
                n_err++; $display("FAIL wrap_empty_r%0d empty=%b unf=%b exp 1/0", r, empty_b, unf_b); end
            if (r == 0) for (int i = 0; i < 5; i++) push_b(8'h50 + 8'(i));
        end
        n_cmp++; if (ovf_b !== 1) begin
            n_err++; $display("FAIL overflow_sticky ovf=%b exp 1", ovf_b); end
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        n_cmp++; if (ovf_b !== 0) begin
            n_err++; $display("FAIL overflow_clear ovf=%b exp 0", ovf_b); end
    endtask

    task automatic test_back_to_back();
        push_a(8'h01);
        push_a(8'h02);
        bus_a.i_valid_s = 1'b1;
        bus_a.i_ready_m = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_a.i_datain = 8'h03 + 8'(i);
            n_cmp++; if (cnt_a !== 2 || bus_a.o_dataout !== 8'h01 + 8'(i)) begin
                n_err++; $display("FAIL b2b_%0d cnt=%0d data=%h exp 2/%h", i, cnt_a, bus_a.o_dataout,
                                  8'h01 + 8'(i)); end
            @(negedge clk);
        end
        bus_a.i_valid_s = 1'b0;
        n_cmp++; if (cnt_a !== 2 || bus_a.o_dataout !== 8'h0B) begin
            n_err++; $display("FAIL b2b_after cnt=%0d data=%h exp 2/0b", cnt_a, bus_a.o_dataout); end
        @(negedge clk);
        n_cmp++; if (cnt_a !== 1 || bus_a.o_dataout !== 8'h0C) begin
            n_err++; $display("FAIL b2b_last cnt=%0d data=%h exp 1/0c", cnt_a, bus_a.o_dataout); end
        @(negedge clk);
        // Push and ready together on empty: only the push happens.
        bus_a.i_valid_s = 1'b1;
        bus_a.i_datain  = 8'h99;
        @(negedge clk);
        bus_a.i_valid_s = 1'b0;
        bus_a.i_ready_m = 1'b0;
        n_cmp++; if (cnt_a !== 1 || bus_a.o_dataout !== 8'h99) begin
            n_err++; $display("FAIL empty_push_pop cnt=%0d data=%h exp 1/99", cnt_a, bus_a.o_dataout); end
        pop_a();
    endtask

    task automatic test_levels();
        alf_a = 5'd2; ale_a = 5'd3;
        for (int i = 0; i < 14; i++) push_a(8'(i));
        n_cmp++; if (cnt_a !== 14 || afull_a !== 1) begin
            n_err++; $display("FAIL afull_14 cnt=%0d afull=%b exp 14/1", cnt_a, afull_a); end
        pop_a();
        n_cmp++; if (afull_a !== 0) begin
            n_err++; $display("FAIL afull_13 afull=%b exp 0", afull_a); end
        alf_a = 5'd3;
        #1;
        n_cmp++; if (afull_a !== 1) begin
            n_err++; $display("FAIL afull_lvl_change afull=%b exp 1", afull_a); end
        alf_a = 5'd2;
        for (int i = 0; i < 9; i++) pop_a();
        n_cmp++; if (cnt_a !== 4 || aempty_a !== 0) begin
            n_err++; $display("FAIL aempty_4 cnt=%0d aempty=%b exp 4/0", cnt_a, aempty_a); end
        pop_a();
        n_cmp++; if (aempty_a !== 1 || bus_a.o_dataout !== 8'd11) begin
            n_err++; $display("FAIL aempty_3 aempty=%b data=%h exp 1/0b", aempty_a, bus_a.o_dataout); end
        for (int i = 0; i < 3; i++) pop_a();
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 16; i++) push_a(8'h80 + 8'(i));
        n_cmp++; if (full_a !== 1 || bus_a.o_ready_s !== 0) begin
            n_err++; $display("FAIL a_full full=%b ready=%b exp 1/0", full_a, bus_a.o_ready_s); end
        push_a(8'hFF);
        for (int i = 0; i < 9; i++) pop_a();
        n_cmp++; if (cnt_a !== 7 || ovf_a !== 1 || bus_a.o_dataout !== 8'h89) begin
            n_err++; $display("FAIL pre_flush cnt=%0d ovf=%b data=%h exp 7/1/89", cnt_a, ovf_a, bus_a.o_dataout); end
        flush_a = 1'b1; bus_a.i_valid_s = 1'b1; bus_a.i_ready_m = 1'b1; bus_a.i_datain = 8'h5A;
        @(negedge clk);
        flush_a = 1'b0; bus_a.i_valid_s = 1'b0; bus_a.i_ready_m = 1'b0;
        n_cmp++; if (cnt_a !== 0 || empty_a !== 1 || bus_a.o_valid_m !== 0 || ovf_a !== 1 || unf_a !== 0) begin
            n_err++; $display("FAIL flush cnt=%0d empty=%b valid=%b ovf=%b unf=%b exp 0/1/0/1/0",
                              cnt_a, empty_a, bus_a.o_valid_m, ovf_a, unf_a); end
        bus_a.i_valid_s = 1'b1; bus_a.i_datain = 8'h77;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cnt_a !== 0 || empty_a !== 1 || bus_a.o_ready_s !== 1 || bus_a.o_valid_m !== 0) begin
            n_err++; $display("FAIL midreset_state cnt=%0d empty=%b ready=%b valid=%b exp 0/1/1/0",
                              cnt_a, empty_a, bus_a.o_ready_s, bus_a.o_valid_m); end
        n_cmp++; if (ovf_a !== 0 || bus_a.o_dataout !== 8'h00 || full_a !== 0) begin
            n_err++; $display("FAIL midreset_out ovf=%b data=%h full=%b exp 0/00/0",
                              ovf_a, bus_a.o_dataout, full_a); end
        bus_a.i_valid_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cnt_a !== 0 || bus_a.o_valid_m !== 0) begin
            n_err++; $display("FAIL post_reset cnt=%0d valid=%b exp 0/0", cnt_a, bus_a.o_valid_m); end
    endtask

    initial begin
        bus_a.i_valid_s = 1'b0; bus_a.i_datain = '0; bus_a.i_ready_m = 1'b0;
        bus_b.i_valid_s = 1'b0; bus_b.i_datain = '0; bus_b.i_ready_m = 1'b0;
        flush_a = 1'b0; clr_a = 1'b0; alf_a = 5'd2; ale_a = 5'd3;
        flush_b = 1'b0; clr_b = 1'b0; alf_b = 3'd1; ale_b = 3'd1;
        test_reset();
        test_fwft_basic();
        test_underflow();
        test_overflow_wrap();
        test_back_to_back();
        test_levels();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
